// File: rtl/lei_pkg.sv
// Shared widths, fill value and loader state for the LEI and its config loader.
package lei_pkg;
  localparam int LE_INPUTS_DEF = 4;
  localparam int SEL_W         = 3;
  localparam logic [SEL_W-1:0] SEL_DISCONNECT = 3'b111;

  typedef enum logic [1:0] {EMPTY, LOADING, FULL} ld_state_e;

  function automatic int cfg_bits(input int le_inputs);
    return le_inputs * 4 * SEL_W;
  endfunction
endpackage

// File: rtl/lei_config_loader.sv
// Serial shadow/active configuration loader feeding the LEI config_data bus.
module lei_config_loader
  import lei_pkg::*;
#(
  parameter int LE_INPUTS = LE_INPUTS_DEF,
  localparam int CFG_BITS = cfg_bits(LE_INPUTS),
  localparam int CNT_W    = $clog2(CFG_BITS + 1)
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                en,
  input  logic                cfg_in,
  input  logic                cfg_valid,
  input  logic                cfg_commit,
  input  logic                cfg_clear,
  output logic [CFG_BITS-1:0] config_data,
  output logic                cfg_out,
  output logic [CNT_W-1:0]    cfg_count,
  output logic                cfg_full,
  output logic                cfg_loaded,
  output logic                cfg_err
);
  localparam logic [CFG_BITS-1:0] FILL    = {(CFG_BITS/SEL_W){SEL_DISCONNECT}};
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(CFG_BITS);

  ld_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic                err_q, err_d;
  logic                loaded_q, loaded_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= EMPTY;
      cnt_q    <= '0;
      shadow_q <= FILL;
      active_q <= FILL;
      err_q    <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      err_q    <= err_d;
      loaded_q <= loaded_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    err_d    = err_q;
    loaded_d = 1'b0;
    if (en) begin
      if (cfg_clear) begin
        shadow_d = FILL;
        cnt_d    = '0;
        state_d  = EMPTY;
        err_d    = 1'b0;
      end else begin
        // Shifting continues in FULL so a chain of loaders passes bits through.
        if (cfg_valid) shadow_d = {cfg_in, shadow_q[CFG_BITS-1:1]};
        if (cfg_commit && state_q == FULL) begin
          active_d = shadow_q;
          loaded_d = 1'b1;
          cnt_d    = cfg_valid ? CNT_W'(1) : '0;
          state_d  = cfg_valid ? LOADING : EMPTY;
        end else begin
          if (cfg_commit) err_d = 1'b1;
          if (cfg_valid && state_q != FULL) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = (cnt_q + CNT_W'(1) == CNT_MAX) ? FULL : LOADING;
          end
        end
      end
    end
  end

  assign config_data = active_q;
  assign cfg_out     = shadow_q[0];
  assign cfg_count   = cnt_q;
  assign cfg_full    = (cnt_q == CNT_MAX);
  assign cfg_loaded  = loaded_q;
  assign cfg_err     = err_q;
endmodule

// File: tb/tb_lei_config_loader.sv
// Scoreboard bench for lei_config_loader: commits push expected words, a monitor checks each cfg_loaded.
module tb_lei_config_loader;
  localparam int CB = 48;
  localparam logic [CB-1:0] ONES = {CB{1'b1}};

  logic          clk = 1'b0;
  logic          nrst, en, cfg_in, cfg_valid, cfg_commit, cfg_clear;
  logic [CB-1:0] config_data;
  logic          cfg_out, cfg_full, cfg_loaded, cfg_err;
  logic [5:0]    cfg_count;

  int checks = 0;
  int failures = 0;
  logic [CB-1:0] sb_q[$];

  lei_config_loader dut (
    .clk(clk), .nrst(nrst), .en(en), .cfg_in(cfg_in), .cfg_valid(cfg_valid),
    .cfg_commit(cfg_commit), .cfg_clear(cfg_clear), .config_data(config_data),
    .cfg_out(cfg_out), .cfg_count(cfg_count), .cfg_full(cfg_full),
    .cfg_loaded(cfg_loaded), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every cfg_loaded pulse must match the oldest expected commit.
  always @(negedge clk) begin
    if (nrst === 1'b1 && cfg_loaded === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_loaded: got pulse with data %0h expected no pulse", config_data);
      end else begin
        chk("sb_config_data", 64'(config_data), 64'(sb_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [CB-1:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      cfg_in = p[i];
      cfg_valid = 1'b1;
      tick();
    end
    cfg_valid = 1'b0;
    cfg_in = 1'b0;
  endtask

  logic [CB-1:0] p1, p3, e5;

  initial begin
    p1 = 48'hFFFF_FFFF_FFFA;
    p3 = 48'hA5C3_0F1E_9B27;
    e5 = {5'b0, p3[CB-1:5]};
    nrst = 1'b0; en = 1'b1; cfg_in = 1'b0; cfg_valid = 1'b0; cfg_commit = 1'b0; cfg_clear = 1'b0;
    tick(); tick();
    nrst = 1'b1;
    tick(); tick();

    // Reset / idle state
    chk("rst_config_data", 64'(config_data), 64'(ONES));
    chk("rst_count", 64'(cfg_count), 64'd0);
    chk("rst_full", 64'(cfg_full), 64'd0);
    chk("rst_err", 64'(cfg_err), 64'd0);
    chk("rst_out", 64'(cfg_out), 64'd1);
    chk("rst_loaded", 64'(cfg_loaded), 64'd0);

    // Full load, commit
    shift_bits(p1, CB);
    chk("p1_count", 64'(cfg_count), 64'd48);
    chk("p1_full", 64'(cfg_full), 64'd1);
    chk("p1_out", 64'(cfg_out), 64'd0);
    sb_q.push_back(p1);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    chk("p1_loaded_hi", 64'(cfg_loaded), 64'd1);
    chk("p1_config_data", 64'(config_data), 64'(p1));
    chk("p1_count_after", 64'(cfg_count), 64'd0);
    tick();
    chk("p1_loaded_lo", 64'(cfg_loaded), 64'd0);

    // Early commit sets err; clear (with valid+commit) resets err and refills shadow
    shift_bits('0, 20);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    chk("early_err", 64'(cfg_err), 64'd1);
    chk("early_loaded", 64'(cfg_loaded), 64'd0);
    chk("early_config_data", 64'(config_data), 64'(p1));
    chk("early_count", 64'(cfg_count), 64'd20);
    cfg_clear = 1'b1; cfg_valid = 1'b1; cfg_commit = 1'b1;
    tick();
    cfg_clear = 1'b0; cfg_valid = 1'b0; cfg_commit = 1'b0;
    chk("clr_err", 64'(cfg_err), 64'd0);
    chk("clr_count", 64'(cfg_count), 64'd0);
    chk("clr_config_data", 64'(config_data), 64'(p1));
    shift_bits('0, 28);
    chk("clr_shadow_ones", 64'(cfg_out), 64'd1);
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;

    // Saturation and daisy-chain output
    shift_bits(p3, CB);
    chk("p3_count", 64'(cfg_count), 64'd48);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("chain_out_%0d", k), 64'(cfg_out), 64'(p3[k]));
      cfg_in = 1'b0;
      cfg_valid = 1'b1;
      tick();
    end
    cfg_valid = 1'b0;
    chk("sat_count", 64'(cfg_count), 64'd48);
    chk("sat_full", 64'(cfg_full), 64'd1);
    chk("chain_out_5", 64'(cfg_out), 64'(p3[5]));

    // Commit together with a valid bit
    sb_q.push_back(e5);
    cfg_commit = 1'b1; cfg_valid = 1'b1; cfg_in = 1'b1;
    tick();
    cfg_commit = 1'b0; cfg_valid = 1'b0; cfg_in = 1'b0;
    chk("cv_loaded", 64'(cfg_loaded), 64'd1);
    chk("cv_config_data", 64'(config_data), 64'(e5));
    chk("cv_count", 64'(cfg_count), 64'd1);
    chk("cv_full", 64'(cfg_full), 64'd0);
    shift_bits('0, 47);
    chk("cv_refill_count", 64'(cfg_count), 64'd48);
    chk("cv_refill_out", 64'(cfg_out), 64'd1);

    // en=0 holds everything
    for (int i = 0; i < 10; i++) begin
      en = 1'b0;
      cfg_valid = i[0]; cfg_commit = i[1]; cfg_clear = i[2]; cfg_in = ~i[0];
      tick();
      chk("hold_count", 64'(cfg_count), 64'd48);
      chk("hold_config_data", 64'(config_data), 64'(e5));
      chk("hold_loaded", 64'(cfg_loaded), 64'd0);
      chk("hold_out", 64'(cfg_out), 64'd1);
    end
    en = 1'b1; cfg_valid = 1'b0; cfg_commit = 1'b0; cfg_clear = 1'b0; cfg_in = 1'b0;

    // Async reset mid-load
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
    shift_bits(p3, 30);
    chk("pre_rst_count", 64'(cfg_count), 64'd30);
    #2 nrst = 1'b0;
    #1;
    chk("async_rst_config_data", 64'(config_data), 64'(ONES));
    chk("async_rst_count", 64'(cfg_count), 64'd0);
    chk("async_rst_out", 64'(cfg_out), 64'd1);
    tick();
    nrst = 1'b1;
    tick();

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
